// File: rtl/button_conditioner_if.sv
// Button bundle between the raw push-button pins and the mode FSM / adjust counters.
// The conditioner uses the slave side; the consumer (or a bench) uses the master side.
interface button_conditioner_if #(
    parameter int N_BTN = 3
);
    logic [N_BTN-1:0] btn_raw;
    logic [N_BTN-1:0] level;
    logic [N_BTN-1:0] pulse;
    logic [N_BTN-1:0] held;

    modport master (output btn_raw, input level, pulse, held);
    modport slave  (input btn_raw, output level, pulse, held);
endinterface

// File: rtl/button_conditioner.sv
// Per-button synchroniser, debouncer, press strobe and optional auto-repeat.
// Auto-repeat is built only when BUTTON_AUTO_REPEAT_EN is defined.
//
// state     | meaning
// IDLE      | button released and stable
// PRESS_DEB | synchronised input high, counting toward an accepted press
// DOWN      | press accepted, level high, waiting for release or repeat delay
// REPEAT    | auto-repeat phase, pulse every REP_PERIOD cycles, held high
// REL_DEB   | synchronised input low, counting toward an accepted release
module button_conditioner #(
    parameter int               N_BTN      = 3,
    parameter int               DEB_CYCLES = 16,
    parameter int               REP_DELAY  = 500,
    parameter int               REP_PERIOD = 100,
    parameter logic [N_BTN-1:0] REP_MASK   = 3'b110,
    parameter int               CNT_W      = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    button_conditioner_if.slave  bus
);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        PRESS_DEB = 3'd1,
        DOWN      = 3'd2,
        REPEAT    = 3'd3,
        REL_DEB   = 3'd4
    } state_t;

`ifdef BUTTON_AUTO_REPEAT_EN
    localparam bit REPEAT_ON = 1'b1;
`else
    localparam bit REPEAT_ON = 1'b0;
`endif

    localparam logic [N_BTN-1:0] REP_EN  = REP_MASK & {N_BTN{REPEAT_ON}};
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] DEB_C   = CNT_W'(DEB_CYCLES);
    localparam logic [CNT_W-1:0] DLY_C   = CNT_W'(REP_DELAY);
    localparam logic [CNT_W-1:0] PER_C   = CNT_W'(REP_PERIOD);

    localparam int MAX_A   = (DEB_CYCLES > REP_DELAY) ? DEB_CYCLES : REP_DELAY;
    localparam int MAX_CNT = (MAX_A > REP_PERIOD) ? MAX_A : REP_PERIOD;

    if (longint'(MAX_CNT) >= (longint'(1) << CNT_W)) begin : g_cfg_err
        $error("button_conditioner: CNT_W=%0d cannot hold count %0d", CNT_W, MAX_CNT);
    end

    logic [N_BTN-1:0] sync_a;
    logic [N_BTN-1:0] sync_s;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync_a <= '0;
            sync_s <= '0;
        end else begin
            sync_a <= bus.btn_raw;
            sync_s <= sync_a;
        end
    end

    for (genvar i = 0; i < N_BTN; i++) begin : g_btn
        state_t           state, state_n;
        logic [CNT_W-1:0] cnt, cnt_n, cnt_inc;
        logic             level_q, level_n;
        logic             pulse_q, pulse_n;
        logic             held_q, held_n;

        // saturating increment so a long hold in DOWN never wraps back into a repeat
        assign cnt_inc = (cnt == CNT_MAX) ? cnt : cnt + CNT_ONE;

        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                state   <= IDLE;
                cnt     <= '0;
                level_q <= 1'b0;
                pulse_q <= 1'b0;
                held_q  <= 1'b0;
            end else begin
                state   <= state_n;
                cnt     <= cnt_n;
                level_q <= level_n;
                pulse_q <= pulse_n;
                held_q  <= held_n;
            end
        end

        always_comb begin
            state_n = state;
            cnt_n   = cnt_inc;
            level_n = level_q;
            pulse_n = 1'b0;
            held_n  = held_q;
            case (state)
                IDLE: begin
                    cnt_n = '0;
                    if (sync_s[i]) begin
                        if (CNT_ONE >= DEB_C) begin
                            state_n = DOWN;
                            level_n = 1'b1;
                            pulse_n = 1'b1;
                        end else begin
                            state_n = PRESS_DEB;
                            cnt_n   = CNT_ONE;
                        end
                    end
                end
                PRESS_DEB: begin
                    if (!sync_s[i]) begin
                        state_n = IDLE;
                        cnt_n   = '0;
                    end else if (cnt_inc >= DEB_C) begin
                        state_n = DOWN;
                        level_n = 1'b1;
                        pulse_n = 1'b1;
                        cnt_n   = '0;
                    end
                end
                DOWN: begin
                    if (!sync_s[i]) begin
                        state_n = REL_DEB;
                        cnt_n   = CNT_ONE;
                    end else if (REP_EN[i] && (cnt_inc >= DLY_C)) begin
                        state_n = REPEAT;
                        pulse_n = 1'b1;
                        held_n  = 1'b1;
                        cnt_n   = '0;
                    end
                end
                REPEAT: begin
                    if (!sync_s[i]) begin
                        state_n = REL_DEB;
                        cnt_n   = CNT_ONE;
                        held_n  = 1'b0;
                    end else if (cnt_inc >= PER_C) begin
                        pulse_n = 1'b1;
                        cnt_n   = '0;
                    end
                end
                REL_DEB: begin
                    if (sync_s[i]) begin
                        state_n = DOWN;
                        cnt_n   = '0;
                    end else if (cnt_inc >= DEB_C) begin
                        state_n = IDLE;
                        level_n = 1'b0;
                        cnt_n   = '0;
                    end
                end
                default: begin
                    state_n = IDLE;
                    cnt_n   = '0;
                    level_n = 1'b0;
                    held_n  = 1'b0;
                end
            endcase
        end

        assign bus.level[i] = level_q;
        assign bus.pulse[i] = pulse_q;
        assign bus.held[i]  = held_q;
    end

endmodule

// File: doc/button_conditioner.md
Name: button_conditioner

Overview:
- Upstream stage of the clock/alarm top: conditions the raw push-buttons (modo, mais, menos) before they reach the mode FSM and the adjust counters.
- Per button: synchronises, debounces, and emits a single-cycle press pulse plus a clean level.
- Optionally emits auto-repeat pulses while a button is held, for fast hour/minute adjust.
- Outputs are synchronous to clk and replace direct use of raw button inputs as clocks.

Parameters:
N_BTN, 3, number of buttons; bit 0 = modo, bit 1 = mais, bit 2 = menos
DEB_CYCLES, 16, consecutive stable samples required to accept a press or a release
REP_DELAY, 500, cycles from the accepted press to the first repeat pulse
REP_PERIOD, 100, cycles between subsequent repeat pulses
REP_MASK, 3'b110, per-button repeat enable; modo never repeats by default
CNT_W, 16, width of the per-button counters; must hold max(DEB_CYCLES, REP_DELAY, REP_PERIOD)

Ports:
clk  input  1  system clock, single clock domain
rst  input  1  asynchronous active-low reset
btn_raw  input  N_BTN  raw asynchronous button levels, active-high
level  output  N_BTN  debounced button level
pulse  output  N_BTN  one-cycle strobe on accepted press and on each repeat
held  output  N_BTN  high while the button is in the repeat phase

Behaviour:
- Reset (rst=0, asynchronous):
  - Synchroniser flops, counters, FSMs and all outputs go to 0; every FSM enters IDLE.
  - Release of reset is sampled on the next clk rising edge.
- Synchroniser: two-flop chain per bit; s = second stage. All decisions use s only.
- Per-button FSM, fully independent per bit:
  - IDLE: cnt=0. If s=1, go to PRESS_DEB with cnt=1.
  - PRESS_DEB: if s=0, return to IDLE and clear cnt. Otherwise cnt++. When cnt reaches DEB_CYCLES: go to DOWN, set level=1, pulse=1 for exactly that cycle, clear cnt.
  - DOWN: cnt++ each cycle.
    - If s=0, go to REL_DEB with cnt=1.
    - Else, if REP_MASK bit is set and cnt reaches REP_DELAY: go to REPEAT, pulse=1, held=1, clear cnt.
  - REPEAT: cnt++ each cycle.
    - If s=0, go to REL_DEB with cnt=1 and held=0.
    - Else, when cnt reaches REP_PERIOD: pulse=1 and clear cnt.
  - REL_DEB: if s=1, return to DOWN with cnt cleared, and no new pulse is issued. Otherwise cnt++. When cnt reaches DEB_CYCLES: go to IDLE and set level=0. No pulse is issued on release.
- Latency: a clean raw rising edge sampled at edge t gives pulse high in cycle t+2+DEB_CYCLES-1. This is fixed and the bench checks it exactly.
- Bounces shorter than DEB_CYCLES never produce a pulse and never change level.
- held is 0 outside REPEAT. pulse is never high in two consecutive cycles unless REP_PERIOD=1.
- Simultaneous presses on different bits: each bit pulses independently, with no priority and no suppression.
- Reset mid-press: all outputs drop to 0 immediately. A button still held after reset release is treated as a new press and must be debounced again.
- Counters saturate, never wrap. A parameter set where CNT_W cannot hold the largest count is a configuration error, flagged with a simulation-time check.

Optional Feature:
- Macro: BUTTON_AUTO_REPEAT_EN.
- Defined: REPEAT state and the REP_DELAY/REP_PERIOD logic are present, as described above.
- Undefined:
  - DOWN never leaves to REPEAT.
  - held is tied to 0 and REP_MASK is ignored.
  - Exactly one pulse per debounced press.

Test Plan (DEB_CYCLES=4, REP_DELAY=20, REP_PERIOD=5, macro defined unless stated):
- Reset: drive rst=0 while btn_raw=3'b111 -> level=pulse=held=0 throughout; after release, a pulse appears only after the full debounce.
- Clean press: raise mais (bit 1) at edge 10, hold 10 cycles -> pulse[1] high only in cycle 15, level[1]=1 from 15, no pulse on release, level[1]=0 four cycles after the synchronised fall.
- Bounce: toggle menos with high runs of 1, 2 and 3 cycles -> pulse=0 and level=0 throughout.
- Auto-repeat: hold menos for 60 cycles after acceptance -> pulses at +0, +20, +25, +30, ..., +55; held=1 from +20 until release.
- No repeat on modo: hold modo for 60 cycles -> exactly one pulse[0] and held[0]=0. With the macro undefined and mais held 60 cycles -> exactly one pulse[1].
- Simultaneous press plus mid-press reset: press mais and menos on the same edge -> both pulse in the same cycle. Assert rst at accept+3 -> all outputs 0 at once. Release rst with buttons still held -> new pulses 2+4-1 cycles later.
